// File: rtl/quo_bin2bcd_if.sv
// Handshake and data bundle between a binary source (typically a divider)
// and the quotient/remainder BCD converter.
interface quo_bin2bcd_if #(
    parameter int W = 8,
    parameter int D = 3
);
    logic           start;
    logic [W-1:0]   quo;
    logic [W-1:0]   rmd;
    logic           ready;
    logic           done_tick;
    logic [4*D-1:0] quo_bcd;
    logic [4*D-1:0] rmd_bcd;

    modport master (
        output start, quo, rmd,
        input  ready, done_tick, quo_bcd, rmd_bcd
    );

    modport slave (
        input  start, quo, rmd,
        output ready, done_tick, quo_bcd, rmd_bcd
    );
endinterface

// File: rtl/quo_bin2bcd.sv
// Dual-channel double-dabble converter: turns a W-bit quotient and remainder
// into packed BCD in exactly W shift cycles, then pulses done_tick once.
module quo_bin2bcd #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic          clk,
    input  logic          reset,
    quo_bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            w_ready;
    logic            w_done;
    logic            w_lastStep;

    logic [W-1:0]    r_quoBin;
    logic [W-1:0]    r_rmdBin;
    logic [BW-1:0]   r_quoWork;
    logic [BW-1:0]   r_rmdWork;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_quoBcd;
    logic [BW-1:0]   r_rmdBcd;

    logic [BW-1:0]   w_quoAdj;
    logic [BW-1:0]   w_rmdAdj;
    logic [BW+W-1:0] w_quoShift;
    logic [BW+W-1:0] w_rmdShift;

    // Each digit is adjusted on its own; no carry ever crosses into the next digit.
    function automatic logic [BW-1:0] dabbleAdjust(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        res = v;
        for (int k = 0; k < D; k++) begin
            if (v[4*k +: 4] > 4'd4) begin
                res[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    assign w_quoAdj   = dabbleAdjust(r_quoWork);
    assign w_rmdAdj   = dabbleAdjust(r_rmdWork);
    assign w_quoShift = {w_quoAdj, r_quoBin} << 1;
    assign w_rmdShift = {w_rmdAdj, r_rmdBin} << 1;

    // A counter of 0 while in OP is unreachable, but treating it as the last
    // step guarantees the block can never wrap and spin in OP.
    assign w_lastStep = (r_cnt <= CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = IDLE;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready     = 1'b1;
                w_stateNext = bus.start ? OP : IDLE;
            end
            OP: begin
                w_stateNext = w_lastStep ? DONE : OP;
            end
            DONE: begin
                w_done      = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quoBin  <= '0;
            r_rmdBin  <= '0;
            r_quoWork <= '0;
            r_rmdWork <= '0;
            r_cnt     <= '0;
            r_quoBcd  <= '0;
            r_rmdBcd  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_quoBin  <= bus.quo;
                        r_rmdBin  <= bus.rmd;
                        r_quoWork <= '0;
                        r_rmdWork <= '0;
                        r_cnt     <= CW'(W);
                    end
                end
                OP: begin
                    r_quoBin  <= w_quoShift[W-1:0];
                    r_rmdBin  <= w_rmdShift[W-1:0];
                    r_quoWork <= w_quoShift[BW+W-1:W];
                    r_rmdWork <= w_rmdShift[BW+W-1:W];
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if (w_lastStep) begin
                        r_quoBcd <= w_quoShift[BW+W-1:W];
                        r_rmdBcd <= w_rmdShift[BW+W-1:W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready     = w_ready;
    assign bus.done_tick = w_done;
    assign bus.quo_bcd   = r_quoBcd;
    assign bus.rmd_bcd   = r_rmdBcd;
endmodule

// File: tb/tb_quo_bin2bcd.sv
// Directed-vector bench for quo_bin2bcd (W=8, D=3): latency, digit
// boundaries, busy/hold behaviour, input isolation, mid-op reset, chaining.
module tb_quo_bin2bcd;
    localparam int W = 8;
    localparam int D = 3;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    quo_bin2bcd_if #(.W(W), .D(D)) bus ();

    quo_bin2bcd #(.W(W), .D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Returns on the falling edge just after the start edge (first OP cycle).
    task automatic convStart(input logic [7:0] q, input logic [7:0] r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.quo   = q;
        bus.rmd   = r;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (bus.done_tick !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (bus.done_tick !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.quo = '0;
        bus.rmd = '0;
        #12;
        vectors++;
        if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        vectors++;
        if (bus.done_tick !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done_tick); end
        vectors++;
        if (bus.quo_bcd !== 12'h000) begin miscompares++; $display("FAIL reset_quo_bcd: got %h expected 000", bus.quo_bcd); end
        vectors++;
        if (bus.rmd_bcd !== 12'h000) begin miscompares++; $display("FAIL reset_rmd_bcd: got %h expected 000", bus.rmd_bcd); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_max_value();
        int c;
        convStart(8'd255, 8'd0);
        vectors++;
        if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL max_ready_low: got %b expected 0", bus.ready); end
        waitDone(c);
        vectors++;
        if (c != 9) begin miscompares++; $display("FAIL max_latency: got %0d expected 9", c); end
        vectors++;
        if (bus.quo_bcd !== 12'h255) begin miscompares++; $display("FAIL max_quo_bcd: got %h expected 255", bus.quo_bcd); end
        vectors++;
        if (bus.rmd_bcd !== 12'h000) begin miscompares++; $display("FAIL max_rmd_bcd: got %h expected 000", bus.rmd_bcd); end
        @(negedge clk);
        vectors++;
        if (bus.done_tick !== 1'b0 || bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL max_one_cycle_done: got done=%b ready=%b expected done=0 ready=1", bus.done_tick, bus.ready);
        end
    endtask

    task automatic test_digit_boundaries();
        logic [7:0]  qv [3] = '{8'd9, 8'd99, 8'd0};
        logic [7:0]  rv [3] = '{8'd10, 8'd100, 8'd199};
        logic [11:0] qe [3] = '{12'h009, 12'h099, 12'h000};
        logic [11:0] re [3] = '{12'h010, 12'h100, 12'h199};
        int c;
        for (int i = 0; i < 3; i++) begin
            convStart(qv[i], rv[i]);
            waitDone(c);
            vectors++;
            if (bus.quo_bcd !== qe[i]) begin miscompares++; $display("FAIL boundary_quo[%0d]: got %h expected %h", i, bus.quo_bcd, qe[i]); end
            vectors++;
            if (bus.rmd_bcd !== re[i]) begin miscompares++; $display("FAIL boundary_rmd[%0d]: got %h expected %h", i, bus.rmd_bcd, re[i]); end
        end
    endtask

    task automatic test_busy_hold();
        int doneCount = 0;
        int doneCycle = -1;
        convStart(8'd37, 8'd0);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.done_tick === 1'b1) begin
                doneCount++;
                doneCycle = c;
            end
            if (c == 5) begin
                vectors++;
                if (bus.quo_bcd !== 12'h000 || bus.rmd_bcd !== 12'h199) begin
                    miscompares++;
                    $display("FAIL busy_hold_prev: got %h/%h expected 000/199", bus.quo_bcd, bus.rmd_bcd);
                end
            end
            bus.start = (c == 4) || (bus.done_tick === 1'b1);
            if (bus.start) bus.quo = 8'd200;
        end
        bus.start = 1'b0;
        vectors++;
        if (doneCount != 1 || doneCycle != 9) begin
            miscompares++;
            $display("FAIL busy_single_done: got count=%0d cycle=%0d expected count=1 cycle=9", doneCount, doneCycle);
        end
        vectors++;
        if (bus.quo_bcd !== 12'h037) begin miscompares++; $display("FAIL busy_quo_bcd: got %h expected 037", bus.quo_bcd); end
        bus.quo = 8'd99;
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.quo_bcd !== 12'h037) begin miscompares++; $display("FAIL busy_hold_idle: got %h expected 037", bus.quo_bcd); end
    endtask

    task automatic test_input_isolation();
        int c;
        @(negedge clk);
        bus.start = 1'b1;
        bus.quo = 8'd128;
        bus.rmd = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.quo = 8'd5;
        bus.rmd = 8'd250;
        waitDone(c);
        vectors++;
        if (bus.quo_bcd !== 12'h128) begin miscompares++; $display("FAIL isolation_quo: got %h expected 128", bus.quo_bcd); end
        vectors++;
        if (bus.rmd_bcd !== 12'h003) begin miscompares++; $display("FAIL isolation_rmd: got %h expected 003", bus.rmd_bcd); end
    endtask

    task automatic test_midop_reset();
        int c;
        int doneSeen = 0;
        convStart(8'd123, 8'd45);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset_ctrl: got ready=%b done=%b expected ready=1 done=0", bus.ready, bus.done_tick);
        end
        vectors++;
        if (bus.quo_bcd !== 12'h000 || bus.rmd_bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL midop_reset_bcd: got %h/%h expected 000/000", bus.quo_bcd, bus.rmd_bcd);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done_tick === 1'b1) doneSeen++;
        end
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.done_tick === 1'b1) doneSeen++;
        end
        vectors++;
        if (doneSeen != 0) begin miscompares++; $display("FAIL midop_no_done: got %0d done pulses expected 0", doneSeen); end
        convStart(8'd42, 8'd0);
        waitDone(c);
        vectors++;
        if (c != 9) begin miscompares++; $display("FAIL midop_restart_latency: got %0d expected 9", c); end
        vectors++;
        if (bus.quo_bcd !== 12'h042) begin miscompares++; $display("FAIL midop_restart_quo: got %h expected 042", bus.quo_bcd); end
    endtask

    task automatic test_back_to_back();
        int c;
        convStart(8'd99, 8'd255);
        waitDone(c);
        vectors++;
        if (c != 9) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 9", c); end
        vectors++;
        if (bus.quo_bcd !== 12'h099 || bus.rmd_bcd !== 12'h255) begin
            miscompares++;
            $display("FAIL b2b_values: got %h/%h expected 099/255", bus.quo_bcd, bus.rmd_bcd);
        end
    endtask

    task automatic test_chaining();
        int c;
        int guard = 0;
        int dividend = 200;
        int divisor = 7;
        while (bus.ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        convStart(8'(dividend / divisor), 8'(dividend % divisor));
        waitDone(c);
        vectors++;
        if (bus.quo_bcd !== 12'h028) begin miscompares++; $display("FAIL chain_quo: got %h expected 028", bus.quo_bcd); end
        vectors++;
        if (bus.rmd_bcd !== 12'h004) begin miscompares++; $display("FAIL chain_rmd: got %h expected 004", bus.rmd_bcd); end
    endtask

    initial begin
        test_reset();
        test_max_value();
        test_digit_boundaries();
        test_busy_hold();
        test_input_isolation();
        test_midop_reset();
        test_back_to_back();
        test_chaining();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
